// File: rtl/driver_tabuleiro.sv
// driver_tabuleiro: 81-cell ultimate tic-tac-toe board store with multiplexed LED scan.
// Optional `BLINK_EN adds a playable-hint blink on the active macro board.
module driver_tabuleiro #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       limpa,
  input  logic       escreve,
  input  logic [8:0] macro,
  input  logic [8:0] micro,
  input  logic       jogador,
  input  logic [8:0] macro_ativo,
  output logic       escrita_ok,
  output logic       ocupada,
  output logic       invalida,
  output logic [8:0] an,
  output logic [8:0] leds_x,
  output logic [8:0] leds_o
);
  localparam int SW = $clog2(SCAN_DIV);
  logic [8:0] x_q [9];
  logic [8:0] x_d [9];
  logic [8:0] o_q [9];
  logic [8:0] o_d [9];
  logic ok_q, ok_d, oc_q, oc_d, inv_q, inv_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d, mi, ci;
  logic [8:0] an_q, an_d, lx_q, lx_d, lo_q, lo_d, empty;
  logic wrap, valid, hint;
  always_comb begin
    mi = '0;
    ci = '0;
    for (int i = 0; i < 9; i++) begin
      if (macro[i]) mi = 4'(i);
      if (micro[i]) ci = 4'(i);
    end
  end
  assign valid = ($countones(macro) == 1) && ($countones(micro) == 1);
  always_comb begin
    x_d = x_q;
    o_d = o_q;
    ok_d = 1'b0;
    oc_d = 1'b0;
    inv_d = 1'b0;
    if (limpa) begin
      x_d = '{default: '0};
      o_d = '{default: '0};
    end else if (escreve) begin
      if (!valid) inv_d = 1'b1;
      else if (x_q[mi][ci] | o_q[mi][ci]) oc_d = 1'b1;
      else begin
        ok_d = 1'b1;
        if (jogador) o_d[mi][ci] = 1'b1;
        else x_d[mi][ci] = 1'b1;
      end
    end
  end
  assign wrap  = cnt_q == SW'(SCAN_DIV - 1);
  assign cnt_d = wrap ? '0 : cnt_q + SW'(1);
  assign idx_d = wrap ? (idx_q == 4'd8 ? 4'd0 : idx_q + 4'd1) : idx_q;
  assign an_d  = 9'b1 << idx_d;
`ifdef BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  logic [BW-1:0] bc_q, bc_d;
  logic tg_q, tg_d;
  always_comb begin
    bc_d = bc_q == BW'(BLINK_DIV - 1) ? '0 : bc_q + BW'(1);
    tg_d = bc_q == BW'(BLINK_DIV - 1) ? ~tg_q : tg_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      bc_q <= '0;
      tg_q <= 1'b0;
    end else begin
      bc_q <= bc_d;
      tg_q <= tg_d;
    end
  end
  // an_q is always one-hot, so equality also rejects zero or multi-hot targets
  assign hint = tg_q && (an_q == macro_ativo);
`else
  logic unused_ativo;
  assign unused_ativo = ^macro_ativo;
  assign hint = 1'b0;
`endif
  assign empty = ~(x_q[idx_q] | o_q[idx_q]);
  assign lx_d  = x_q[idx_q] | ({9{hint}} & empty);
  assign lo_d  = o_q[idx_q] | ({9{hint}} & empty);
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q   <= '{default: '0};
      o_q   <= '{default: '0};
      ok_q  <= 1'b0;
      oc_q  <= 1'b0;
      inv_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= 9'b1;
      lx_q  <= '0;
      lo_q  <= '0;
    end else begin
      x_q   <= x_d;
      o_q   <= o_d;
      ok_q  <= ok_d;
      oc_q  <= oc_d;
      inv_q <= inv_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      lx_q  <= lx_d;
      lo_q  <= lo_d;
    end
  end
  assign escrita_ok = ok_q;
  assign ocupada    = oc_q;
  assign invalida   = inv_q;
  assign an         = an_q;
  assign leds_x     = lx_q;
  assign leds_o     = lo_q;
endmodule

// File: tb/tb_driver_tabuleiro.sv
// tb_driver_tabuleiro: vector table, directed corner sequences and random traffic vs a board model.
module tb_driver_tabuleiro;
  localparam int SD = 4;
  localparam int BD = 8;
  logic clock = 0, reset = 0, limpa = 0, escreve = 0, jogador = 0;
  logic [8:0] macro = 0, micro = 0, macro_ativo = 0;
  logic escrita_ok, ocupada, invalida;
  logic [8:0] an, leds_x, leds_o;
  int errors = 0, checks = 0;
  int mc [81];
  int n = 0;
  logic [2:0] last_ep;
  typedef struct {
    logic l, e;
    logic [8:0] ma, mi;
    logic j;
    logic [2:0] ep;
  } vec_t;
  vec_t tbl [11];
  driver_tabuleiro #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clock(clock), .reset(reset), .limpa(limpa), .escreve(escreve),
    .macro(macro), .micro(micro), .jogador(jogador), .macro_ativo(macro_ativo),
    .escrita_ok(escrita_ok), .ocupada(ocupada), .invalida(invalida),
    .an(an), .leds_x(leds_x), .leds_o(leds_o)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask
  function automatic int pos(input logic [8:0] v);
    for (int i = 0; i < 9; i++) if (v[i]) return i;
    return 0;
  endfunction
  // Predict the post-edge outputs from the board/time model, clock once, then compare.
  task automatic tick();
    logic [8:0] ex, eo, ean;
    logic [2:0] ep;
    int p, c;
    ep = 0; ex = 0; eo = 0; ean = 9'h1; c = 0;
    if (!reset) begin
      if (!limpa && escreve) begin
        if ($countones(macro) != 1 || $countones(micro) != 1) ep = 3'b001;
        else begin
          c = pos(macro) * 9 + pos(micro);
          ep = mc[c] != 0 ? 3'b010 : 3'b100;
        end
      end
      p = (n / SD) % 9;
      for (int k = 0; k < 9; k++) begin
        ex[k] = mc[p*9+k] == 1;
        eo[k] = mc[p*9+k] == 2;
`ifdef BLINK_EN
        if (((n / BD) % 2) == 1 && macro_ativo == 9'(1 << p) && mc[p*9+k] == 0) begin
          ex[k] = 1'b1;
          eo[k] = 1'b1;
        end
`endif
      end
      ean = 9'(1 << (((n + 1) / SD) % 9));
    end
    @(posedge clock);
    if (reset || limpa) foreach (mc[i]) mc[i] = 0;
    if (reset) n = 0;
    else begin
      n++;
      if (ep == 3'b100) mc[c] = jogador ? 2 : 1;
    end
    #1;
    last_ep = ep;
    chk("pulses", {6'b0, escrita_ok, ocupada, invalida}, {6'b0, ep});
    chk("an", an, ean);
    chk("leds_x", leds_x, ex);
    chk("leds_o", leds_o, eo);
  endtask
  task automatic do_reset();
    reset = 1; limpa = 0; escreve = 0;
    tick();
    reset = 0;
  endtask
  initial begin
    int k;
    logic [8:0] an0;
    tbl[0]  = '{0, 1, 9'h001, 9'h010, 0, 3'b100};
    tbl[1]  = '{0, 0, 9'h001, 9'h010, 0, 3'b000};
    tbl[2]  = '{0, 1, 9'h001, 9'h010, 1, 3'b010};
    tbl[3]  = '{0, 1, 9'h003, 9'h010, 0, 3'b001};
    tbl[4]  = '{0, 1, 9'h001, 9'h000, 0, 3'b001};
    tbl[5]  = '{0, 1, 9'h002, 9'h001, 1, 3'b100};
    tbl[6]  = '{0, 1, 9'h002, 9'h001, 0, 3'b010};
    tbl[7]  = '{0, 1, 9'h100, 9'h100, 1, 3'b100};
    tbl[8]  = '{0, 1, 9'h100, 9'h100, 0, 3'b010};
    tbl[9]  = '{1, 1, 9'h001, 9'h010, 0, 3'b000};
    tbl[10] = '{0, 1, 9'h001, 9'h010, 1, 3'b100};
    // reset state and first scan advance
    do_reset();
    chk("rst_an", an, 9'h001);
    chk("rst_lx", leds_x, 9'h000);
    chk("rst_pulse", {6'b0, escrita_ok, ocupada, invalida}, 9'h000);
    repeat (4) tick();
    chk("an_after4", an, 9'h002);
    // vector table
    for (int i = 0; i < 11; i++) begin
      limpa = tbl[i].l; escreve = tbl[i].e; macro = tbl[i].ma; micro = tbl[i].mi; jogador = tbl[i].j;
      tick();
      chk($sformatf("vec%0d", i), {6'b0, escrita_ok, ocupada, invalida}, {6'b0, tbl[i].ep});
    end
    limpa = 0; escreve = 0;
    // X in board 0 cell 4 is displayed when slot 0 comes round
    do_reset();
    escreve = 1; macro = 9'h001; micro = 9'h010; jogador = 0;
    tick();
    escreve = 0;
    k = 0;
    while (an !== 9'h001 && k < 40) begin tick(); k++; end
    tick();
    tick();
    chk("an_slot0", an, 9'h001);
    chk("slot0_x", leds_x, 9'h010);
    chk("slot0_o", leds_o, 9'h000);
    // fill board 4, then clear together with a write
    for (int i = 0; i < 9; i++) begin
      escreve = 1; macro = 9'h010; micro = 9'(1 << i); jogador = i[0];
      tick();
    end
    limpa = 1; escreve = 1; macro = 9'h010; micro = 9'h001;
    tick();
    chk("limpa_wr", {6'b0, escrita_ok, ocupada, invalida}, 9'h000);
    limpa = 0; escreve = 0;
    tick();
    an0 = an;
    for (int i = 0; i < 36; i++) begin
      tick();
      chk("dark", leds_x | leds_o, 9'h000);
    end
    chk("an_wrap36", an, an0);
`ifdef BLINK_EN
    do_reset();
    macro_ativo = 9'h001;
    escreve = 1; macro = 9'h001; micro = 9'h010; jogador = 0;
    tick();
    escreve = 0;
    repeat (80) tick();
    macro_ativo = 0;
    repeat (40) tick();
`endif
    // random traffic with deliberate collisions on a few boards
    for (int i = 0; i < 600; i++) begin
      reset   = $urandom_range(0, 79) == 0;
      limpa   = $urandom_range(0, 39) == 0;
      escreve = $urandom_range(0, 1) == 1;
      macro   = $urandom_range(0, 7) == 0 ? 9'($urandom) : 9'(1 << $urandom_range(0, 2));
      micro   = $urandom_range(0, 7) == 0 ? 9'($urandom) : 9'(1 << $urandom_range(0, 8));
      jogador = 1'($urandom);
      macro_ativo = $urandom_range(0, 3) == 0 ? 9'($urandom) : 9'(1 << $urandom_range(0, 8));
      tick();
    end
    reset = 0; limpa = 0; escreve = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
